// File: rtl/inst_mem_loader_if.sv
// Byte-receive and instruction-memory write bus of the instruction memory loader.
// slave: the loader side; master: the side feeding bytes and observing the writes.
interface inst_mem_loader_if #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned MEM_DEPTH = 64
);
    localparam int unsigned CW = $clog2(MEM_DEPTH) + 1;

    logic             i_start;
    logic             i_rx_valid;
    logic [7:0]       i_rx_byte;
    logic             o_rx_ready;
    logic             o_inst_mem_wr_en;
    logic [NBITS-1:0] o_inst_mem_data;
    logic [NBITS-1:0] o_inst_mem_addr;
    logic             o_busy;
    logic             o_done;
    logic [CW-1:0]    o_word_count;
    logic             o_overrun;

    modport slave (
        input  i_start, i_rx_valid, i_rx_byte,
        output o_rx_ready, o_inst_mem_wr_en, o_inst_mem_data, o_inst_mem_addr,
        output o_busy, o_done, o_word_count, o_overrun
    );

    modport master (
        output i_start, i_rx_valid, i_rx_byte,
        input  o_rx_ready, o_inst_mem_wr_en, o_inst_mem_data, o_inst_mem_addr,
        input  o_busy, o_done, o_word_count, o_overrun
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: assembles received bytes MSB-first into NBITS-wide
// words and writes each word to instruction memory with a one-cycle strobe.
// The load ends after a HALT_WORD is written or the memory is full.
module inst_mem_loader #(
    parameter int unsigned      NBITS     = 32,
    parameter int unsigned      MEM_DEPTH = 64,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    inst_mem_loader_if.slave  bus
);
    localparam int unsigned BYTES = NBITS / 8;
    localparam int unsigned BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CW    = $clog2(MEM_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] word_q, word_d;   // assembly register
    logic [BIW-1:0]   bidx_q, bidx_d;   // byte index within the current word
    logic [CW-1:0]    widx_q, widx_d;   // word index == words written so far
    logic [NBITS-1:0] data_q, data_d;   // last word presented to memory
    logic [NBITS-1:0] addr_q, addr_d;   // byte address of that word
    logic             ovr_q, ovr_d;

    // State and datapath registers; reset clears everything, memory is untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            bidx_q  <= '0;
            widx_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            widx_q  <= widx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic: byte assembly, word write and termination decisions.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bidx_d  = bidx_q;
        widx_d  = widx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d = RECV;
                    word_d  = '0;
                    bidx_d  = '0;
                    widx_d  = '0;
                    ovr_d   = 1'b0;
                end
            end

            RECV: begin
                if (bus.i_rx_valid) begin
                    word_d = (word_q << 8) | NBITS'(bus.i_rx_byte);
                    if (bidx_q == BIW'(BYTES - 1)) begin
                        // Data/address registers are loaded with the finished word so
                        // they present it during WRITE and then hold it afterwards.
                        state_d = WRITE;
                        data_d  = word_d;
                        addr_d  = NBITS'(widx_q) << 2;
                    end else begin
                        bidx_d = bidx_q + BIW'(1);
                    end
                end
            end

            WRITE: begin
                widx_d = widx_q + CW'(1);
                bidx_d = '0;
                if (bus.i_rx_valid) begin
                    ovr_d = 1'b1;
                end
                if ((data_q == HALT_WORD) || (widx_d == CW'(MEM_DEPTH))) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.o_rx_ready       = (state_q == RECV);
    assign bus.o_inst_mem_wr_en = (state_q == WRITE);
    assign bus.o_inst_mem_data  = data_q;
    assign bus.o_inst_mem_addr  = addr_q;
    assign bus.o_busy           = (state_q == RECV) || (state_q == WRITE);
    assign bus.o_done           = (state_q == DONE);
    assign bus.o_word_count     = widx_q;
    assign bus.o_overrun        = ovr_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: two instances (deep and 4-word memory)
// share the clock; expected {addr,data} writes are queued as words are sent
// and popped by per-instance monitors on every write strobe.
module tb_inst_mem_loader;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_loader_if #(.NBITS(32), .MEM_DEPTH(64)) bus_a ();
    inst_mem_loader_if #(.NBITS(32), .MEM_DEPTH(4))  bus_b ();

    inst_mem_loader #(.NBITS(32), .MEM_DEPTH(64), .HALT_WORD(32'hFFFFFFFF)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    inst_mem_loader #(.NBITS(32), .MEM_DEPTH(4), .HALT_WORD(32'hFFFFFFFF)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_a[$];
    logic [63:0] sb_b[$];
    logic [63:0] exp_a, exp_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitors: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus_a.o_inst_mem_wr_en === 1'b1) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_wr", 64'(bus_a.o_inst_mem_wr_en), 64'd0);
            end else begin
                exp_a = sb_a.pop_front();
                check("a_wr_addr", 64'(bus_a.o_inst_mem_addr), 64'(exp_a[63:32]));
                check("a_wr_data", 64'(bus_a.o_inst_mem_data), 64'(exp_a[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.o_inst_mem_wr_en === 1'b1) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_wr", 64'(bus_b.o_inst_mem_wr_en), 64'd0);
            end else begin
                exp_b = sb_b.pop_front();
                check("b_wr_addr", 64'(bus_b.o_inst_mem_addr), 64'(exp_b[63:32]));
                check("b_wr_data", 64'(bus_b.o_inst_mem_data), 64'(exp_b[31:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit sel, input logic start, input logic valid, input logic [7:0] b);
        if (sel) begin
            bus_b.i_start = start; bus_b.i_rx_valid = valid; bus_b.i_rx_byte = b;
        end else begin
            bus_a.i_start = start; bus_a.i_rx_valid = valid; bus_a.i_rx_byte = b;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus_b.o_rx_ready : bus_a.o_rx_ready;
    endfunction

    function automatic logic done(input bit sel);
        return sel ? bus_b.o_done : bus_a.o_done;
    endfunction

    task automatic push(input bit sel, input logic [31:0] addr, input logic [31:0] data);
        if (sel) sb_b.push_back({addr, data});
        else     sb_a.push_back({addr, data});
    endtask

    task automatic do_start(input bit sel);
        set_in(sel, 1'b1, 1'b0, 8'h00);
        tick();
        set_in(sel, 1'b0, 1'b0, 8'h00);
    endtask

    // Waits for the loader to be ready before presenting a byte, so no byte is
    // ever offered while ready is low unless a test does so on purpose.
    task automatic send_byte(input bit sel, input logic [7:0] b, input int unsigned gap);
        int unsigned n = 0;
        repeat (gap) tick();
        while (!rdy(sel) && n < 16) begin
            tick();
            n++;
        end
        if (!rdy(sel)) begin
            check("rx_ready_timeout", 64'(rdy(sel)), 64'd1);
        end else begin
            set_in(sel, 1'b0, 1'b1, b);
            tick();
            set_in(sel, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input int unsigned maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(sel, w[31-8*i -: 8], (maxgap != 0) ? $urandom_range(maxgap, 0) : 0);
        end
    endtask

    task automatic wait_done(input bit sel);
        int unsigned n = 0;
        while (!done(sel) && n < 200) begin
            tick();
            n++;
        end
        if (!done(sel)) check("done_timeout", 64'(done(sel)), 64'd1);
    endtask

    task automatic check_all_zero_a(input string pfx);
        check({pfx, "_wr_en"},    64'(bus_a.o_inst_mem_wr_en), 64'd0);
        check({pfx, "_rx_ready"}, 64'(bus_a.o_rx_ready),       64'd0);
        check({pfx, "_busy"},     64'(bus_a.o_busy),           64'd0);
        check({pfx, "_done"},     64'(bus_a.o_done),           64'd0);
        check({pfx, "_count"},    64'(bus_a.o_word_count),     64'd0);
        check({pfx, "_data"},     64'(bus_a.o_inst_mem_data),  64'd0);
        check({pfx, "_addr"},     64'(bus_a.o_inst_mem_addr),  64'd0);
        check({pfx, "_overrun"},  64'(bus_a.o_overrun),        64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] words [3];
        words[0] = 32'h12345678;
        words[1] = 32'hABCDEF01;
        words[2] = HALT;

        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero_a("reset");
        rst = 1'b0;
        tick();

        // Back-to-back bytes, three words ending with HALT.
        do_start(1'b0);
        check("start_busy", 64'(bus_a.o_busy), 64'd1);
        for (int i = 0; i < 3; i++) push(1'b0, 32'(i * 4), words[i]);
        for (int i = 0; i < 3; i++) send_word(1'b0, words[i], 0);
        wait_done(1'b0);
        check("b2b_done",    64'(bus_a.o_done),          64'd1);
        check("b2b_busy",    64'(bus_a.o_busy),          64'd0);
        check("b2b_count",   64'(bus_a.o_word_count),    64'd3);
        check("b2b_overrun", 64'(bus_a.o_overrun),       64'd0);
        check("b2b_addr",    64'(bus_a.o_inst_mem_addr), 64'd8);
        check("b2b_ready",   64'(bus_a.o_rx_ready),      64'd0);

        // Same words with random idle gaps between bytes.
        do_start(1'b0);
        check("restart_done",  64'(bus_a.o_done),       64'd0);
        check("restart_count", 64'(bus_a.o_word_count), 64'd0);
        for (int i = 0; i < 3; i++) push(1'b0, 32'(i * 4), words[i]);
        for (int i = 0; i < 3; i++) send_word(1'b0, words[i], 3);
        wait_done(1'b0);
        check("gap_count",   64'(bus_a.o_word_count), 64'd3);
        check("gap_overrun", 64'(bus_a.o_overrun),    64'd0);

        // Byte offered during the WRITE cycle is dropped and flags overrun.
        do_start(1'b0);
        push(1'b0, 32'd0, 32'h11223344);
        send_word(1'b0, 32'h11223344, 0);
        check("wr_cycle_ready", 64'(bus_a.o_rx_ready),       64'd0);
        check("wr_cycle_wr_en", 64'(bus_a.o_inst_mem_wr_en), 64'd1);
        set_in(1'b0, 1'b0, 1'b1, 8'h55);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        check("ovr_set", 64'(bus_a.o_overrun), 64'd1);
        push(1'b0, 32'd4, HALT);
        send_word(1'b0, HALT, 0);
        wait_done(1'b0);
        check("ovr_sticky", 64'(bus_a.o_overrun),    64'd1);
        check("ovr_count",  64'(bus_a.o_word_count), 64'd2);

        // Reset after two bytes discards the partial word.
        do_start(1'b0);
        check("pre_rst_ovr_clr", 64'(bus_a.o_overrun), 64'd0);
        send_byte(1'b0, 8'h12, 0);
        send_byte(1'b0, 8'h34, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero_a("midrst");
        tick();
        set_in(1'b0, 1'b0, 1'b1, 8'h99);
        repeat (2) tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        check("idle_ignore_ovr",  64'(bus_a.o_overrun), 64'd0);
        check("idle_ignore_busy", 64'(bus_a.o_busy),    64'd0);
        do_start(1'b0);
        push(1'b0, 32'd0, 32'hDEADBEEF);
        push(1'b0, 32'd4, HALT);
        send_word(1'b0, 32'hDEADBEEF, 0);
        send_word(1'b0, HALT, 0);
        wait_done(1'b0);
        check("post_rst_count", 64'(bus_a.o_word_count), 64'd2);

        // Restart from DONE with only a HALT word.
        do_start(1'b0);
        check("halt_only_done_fall", 64'(bus_a.o_done),       64'd0);
        check("halt_only_count0",    64'(bus_a.o_word_count), 64'd0);
        push(1'b0, 32'd0, HALT);
        send_word(1'b0, HALT, 0);
        wait_done(1'b0);
        check("halt_only_count", 64'(bus_a.o_word_count),    64'd1);
        check("halt_only_done",  64'(bus_a.o_done),          64'd1);
        check("halt_only_addr",  64'(bus_a.o_inst_mem_addr), 64'd0);

        // 4-word memory fills without a HALT; extra bytes are ignored.
        do_start(1'b1);
        for (int i = 0; i < 4; i++) push(1'b1, 32'(i * 4), 32'(i + 1));
        for (int i = 0; i < 4; i++) send_word(1'b1, 32'(i + 1), 1);
        wait_done(1'b1);
        check("full_count", 64'(bus_b.o_word_count), 64'd4);
        check("full_done",  64'(bus_b.o_done),       64'd1);
        set_in(1'b1, 1'b0, 1'b1, 8'hAA);
        repeat (8) tick();
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        check("full_overrun",    64'(bus_b.o_overrun),       64'd0);
        check("full_done_hold",  64'(bus_b.o_done),          64'd1);
        check("full_count_hold", 64'(bus_b.o_word_count),    64'd4);
        check("full_addr_hold",  64'(bus_b.o_inst_mem_addr), 64'd12);

        repeat (4) tick();
        check("sb_a_empty", 64'(sb_a.size()), 64'd0);
        check("sb_b_empty", 64'(sb_b.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Byte-stream-to-word writer for the instruction memory. It fills the memory that the instruction fetch stage reads.
- Takes 8-bit bytes from the debug/UART receive path and assembles them into NBITS-wide words.
- Drives the instruction memory write-enable and write-data pins with one single-cycle pulse per word.
- Stops on a HALT word or when memory is full, then signals done so the fetch stage can be released.

Parameters:
- NBITS, 32, instruction word width; must be a multiple of 8.
- MEM_DEPTH, 64, instruction memory capacity in words.
- HALT_WORD, 32'hFFFFFFFF, terminator word; it is written to memory, then the load ends.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_start  input  1  begin a load at word 0; honoured only in IDLE or DONE
- i_rx_valid  input  1  i_rx_byte valid this cycle
- i_rx_byte  input  8  received byte
- o_rx_ready  output  1  loader accepts a byte this cycle
- o_inst_mem_wr_en  output  1  one-cycle write strobe to instruction memory
- o_inst_mem_data  output  NBITS  word to write
- o_inst_mem_addr  output  NBITS  byte address of the word (word_index*4)
- o_busy  output  1  load in progress
- o_done  output  1  load finished
- o_word_count  output  $clog2(MEM_DEPTH)+1  number of words written so far
- o_overrun  output  1  sticky: a byte arrived while o_rx_ready=0 during RECV/WRITE

Behaviour:
- Reset (i_rst=1 at a clock edge) values: state=IDLE; all outputs 0; word index, byte index and assembly register cleared. Reset mid-load discards any partial word; memory contents are not touched.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - o_rx_ready=0; bytes are ignored and o_overrun is not set.
  - i_start=1 -> RECV next cycle, with word index=0, byte index=0 and o_overrun cleared.
- RECV:
  - o_rx_ready=1, o_busy=1.
  - On i_rx_valid, the byte is shifted in MSB-first: the first byte lands in [NBITS-1:NBITS-8] and the last byte in [7:0].
  - Byte index counts 0..NBITS/8-1. When the last byte is accepted -> WRITE next cycle.
  - No valid byte: hold state, no timeout.
- WRITE (exactly 1 cycle):
  - o_inst_mem_wr_en=1, o_inst_mem_data=assembled word, o_inst_mem_addr=word_index<<2, o_rx_ready=0.
  - On exit: word_index and o_word_count increment; byte index resets to 0.
  - Next state: DONE if the word equals HALT_WORD or the incremented count equals MEM_DEPTH; otherwise RECV.
  - A byte with i_rx_valid=1 during WRITE is dropped and sets o_overrun.
- DONE:
  - o_done=1, o_busy=0, o_rx_ready=0; bytes are ignored.
  - o_word_count and o_inst_mem_addr hold their last values.
  - i_start=1 -> RECV with index and count cleared, o_done falls next cycle.
- o_inst_mem_wr_en is 0 in every state except WRITE, and is never asserted for a partial word.
- o_inst_mem_data and o_inst_mem_addr hold their last written values outside WRITE.
- Priority: i_rst > all. i_start is ignored in RECV/WRITE; no restart mid-load.
- Latency:
  - Last byte accepted at cycle N -> wr_en pulse at N+1.
  - Next byte can be accepted at N+2.
  - Sustained throughput: 1 word per NBITS/8+1 cycles.
- Width rule: the word counter saturates at MEM_DEPTH because the load terminates; addresses never wrap.

Test Plan:
- Reset, i_start, then bytes 12 34 56 78, AB CD EF 01, FF FF FF FF back-to-back -> three wr_en pulses: data 0x12345678 @addr 0, 0xABCDEF01 @4, 0xFFFFFFFF @8; then o_done=1, o_word_count=3, o_overrun=0.
- Bytes with gaps (i_rx_valid toggled, random idle cycles) -> same words and addresses as the back-to-back case; no extra wr_en pulses.
- MEM_DEPTH=4 and 4 non-HALT words (0x00000001..0x00000004) -> writes at addr 0,4,8,12; DONE after the 4th write; 5th word's bytes ignored, no wr_en, o_overrun stays 0.
- Byte presented in the WRITE cycle -> byte dropped, o_overrun=1 and sticky; next word assembles from subsequent bytes only.
- i_rst asserted after 2 bytes of word 1 -> all outputs 0, state IDLE, no wr_en. Then i_start plus 0xDEADBEEF, HALT -> 0xDEADBEEF written at addr 0.
- In DONE, i_start again and HALT only -> o_done drops; 0xFFFFFFFF written at addr 0; o_word_count=1; o_done returns.
